// File: rtl/data_sram_resp.sv
// SRAM-like data port responder: in-order response queue with a fixed latency,
// or a per-transaction random latency of 1..4 when DATA_SRAM_RAND_LAT_EN is defined.
module data_sram_resp #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned FIXED_LAT   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned LAT_W = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]      mem_q    [MEM_WORDS];
  logic             q_wr_q   [OUTSTANDING];
  logic [31:0]      q_word_q [OUTSTANDING];

  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             hs_c;
  logic             retire_c;
  logic             load_c;
  logic [LAT_W-1:0] lat_c;
  logic [IDX_W-1:0] idx_c;
  logic             head_wr_c;
  logic [31:0]      head_word_c;
  logic             unused_c;

  assign idx_c    = data_sram_addr[IDX_W+1:2];
  assign unused_c = ^{data_sram_size, data_sram_addr[31:IDX_W+2], data_sram_addr[1:0]};

  // No same-cycle bypass: a retiring entry frees its slot only on the next cycle.
  assign data_sram_addr_ok = resetn & (count_q < CNT_W'(OUTSTANDING));
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

`ifdef DATA_SRAM_RAND_LAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every clock.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    lat_c  = LAT_W'(lfsr_q[1:0]) + LAT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign lat_c = LAT_W'(FIXED_LAT);
`endif

  // Queue pointers and occupancy.
  always_comb begin
    hs_c     = data_sram_req & data_sram_addr_ok;
    retire_c = data_ok_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (hs_c)
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (retire_c)
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(hs_c) - CNT_W'(retire_c);
  end

  // Head state machine; a head load either waits lat-1 cycles or responds at once.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    load_c    = 1'b0;
    case (state_q)
      S_IDLE: load_c = hs_c;
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (lat_cnt_q == LAT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (count_d != '0) load_c = 1'b1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (load_c) begin
      lat_cnt_d = lat_c - LAT_W'(1);
      state_d   = (lat_c == LAT_W'(1)) ? S_RESP : S_WAIT;
    end
  end

  // Next head entry; with lat=1 it may be the entry being accepted this cycle.
  always_comb begin
    if (hs_c && (rd_ptr_d == wr_ptr_q)) begin
      head_wr_c   = data_sram_wr;
      head_word_c = mem_q[idx_c];
    end else begin
      head_wr_c   = q_wr_q[rd_ptr_d];
      head_word_c = q_word_q[rd_ptr_d];
    end
    data_ok_d = (state_d == S_RESP);
    rdata_d   = (data_ok_d && !head_wr_c) ? head_word_c : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory and queue payload are not reset; reads capture the pre-write word.
  always_ff @(posedge clk) begin
    if (hs_c) begin
      q_wr_q[wr_ptr_q]   <= data_sram_wr;
      q_word_q[wr_ptr_q] <= mem_q[idx_c];
      if (data_sram_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (data_sram_wstrb[i]) mem_q[idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
